// File: rtl/tqvp_bus_pkg.sv
// ============================================================================
// tqvp_bus_pkg : shared encodings and helpers for the TinyQV peripheral bus
// Revision     : 1.0
// ============================================================================
`default_nettype none

package tqvp_bus_pkg;

    localparam logic [1:0] SZ_8     = 2'b00;
    localparam logic [1:0] SZ_16    = 2'b01;
    localparam logic [1:0] SZ_32    = 2'b10;
    localparam logic [1:0] SZ_NONE  = 2'b11;
    localparam logic [1:0] BUS_IDLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Zero-extend a bus word to the width implied by an access size.
    function automatic logic [31:0] zext_size(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            SZ_8:    return {24'h0, d[7:0]};
            SZ_16:   return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/tqvp_bus_initiator.sv
// ============================================================================
// tqvp_bus_initiator : single-command initiator for the TinyQV peripheral bus
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tqvp_bus_initiator
    import tqvp_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int          TO_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  bus_address,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_write_n,
    output logic [1:0]  bus_read_n,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TO_W-1:0]   r_cnt;
    logic [TO_W-1:0]   w_cnt_nxt;
    logic [1:0]        r_size;
    logic [1:0]        w_size_nxt;
    logic              w_accept;
    logic              w_rsp_load;
    logic              w_rsp_err;
    logic [31:0]       w_rsp_data;

    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic [5:0]        r_bus_address;
    logic [31:0]       r_bus_wdata;
    logic [1:0]        r_bus_write_n;
    logic [1:0]        r_bus_read_n;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_rsp_load  = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_data  = '0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = '0;
                    if (cmd_size == SZ_NONE) begin
                        w_state_nxt = ST_RESP;
                        w_rsp_load  = 1'b1;
                        w_rsp_err   = 1'b1;
                    end else if (cmd_write) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_RESP;
                w_rsp_load  = 1'b1;
            end
            ST_READ: begin
                // Data arriving on the last permitted cycle wins over the timeout.
                if (bus_ready) begin
                    w_state_nxt = ST_RESP;
                    w_rsp_load  = 1'b1;
                    w_rsp_data  = zext_size(bus_rdata, r_size);
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nxt = ST_RESP;
                    w_rsp_load  = 1'b1;
                    w_rsp_err   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_size_nxt = w_accept ? cmd_size : r_size;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_size        <= SZ_8;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_bus_address <= '0;
            r_bus_wdata   <= '0;
            r_bus_write_n <= BUS_IDLE;
            r_bus_read_n  <= BUS_IDLE;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_size        <= w_size_nxt;
            r_cmd_ready   <= (w_state_nxt == ST_IDLE);
            r_rsp_valid   <= (w_state_nxt == ST_RESP);
            r_bus_write_n <= (w_state_nxt == ST_WRITE) ? w_size_nxt : BUS_IDLE;
            r_bus_read_n  <= (w_state_nxt == ST_READ)  ? w_size_nxt : BUS_IDLE;
            if (w_accept) begin
                r_bus_address <= cmd_addr;
                r_bus_wdata   <= cmd_wdata;
            end
            if (w_rsp_load) begin
                r_rsp_rdata <= w_rsp_data;
                r_rsp_err   <= w_rsp_err;
            end
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign bus_address = r_bus_address;
    assign bus_wdata   = r_bus_wdata;
    assign bus_write_n = r_bus_write_n;
    assign bus_read_n  = r_bus_read_n;

endmodule

`default_nettype wire

// File: tb/tb_tqvp_bus_initiator.sv
// ============================================================================
// tb_tqvp_bus_initiator : directed bench for tqvp_bus_initiator (two timeouts)
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_tqvp_bus_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid_a = 1'b0;
    logic        cmd_valid_b = 1'b0;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_size = 2'b00;
    logic [5:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_ready = 1'b0;

    logic        a_cmd_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata, a_bus_wdata;
    logic [5:0]  a_bus_address;
    logic [1:0]  a_bus_write_n, a_bus_read_n;

    logic        b_cmd_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata, b_bus_wdata;
    logic [5:0]  b_bus_address;
    logic [1:0]  b_bus_write_n, b_bus_read_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tqvp_bus_initiator dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_a), .cmd_ready(a_cmd_ready),
        .cmd_write(cmd_write), .cmd_size(cmd_size),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .bus_address(a_bus_address), .bus_wdata(a_bus_wdata),
        .bus_write_n(a_bus_write_n), .bus_read_n(a_bus_read_n),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    tqvp_bus_initiator #(.TIMEOUT(4), .TO_W(16)) dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_b), .cmd_ready(b_cmd_ready),
        .cmd_write(cmd_write), .cmd_size(cmd_size),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .bus_address(b_bus_address), .bus_wdata(b_bus_wdata),
        .bus_write_n(b_bus_write_n), .bus_read_n(b_bus_read_n),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one command to instance A (sel=0) or B (sel=1) for a single edge.
    task automatic issue(input bit sel, input bit wr, input logic [1:0] sz,
                         input logic [5:0] a, input logic [31:0] wd);
        cmd_write = wr;
        cmd_size  = sz;
        cmd_addr  = a;
        cmd_wdata = wd;
        if (sel) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
        step();
        cmd_valid_a = 1'b0;
        cmd_valid_b = 1'b0;
    endtask

    task automatic finish_rsp(input bit sel, input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_rdy_after"}, {31'h0, sel ? b_cmd_ready : a_cmd_ready}, 32'h1);
        chk({tag, "_valid_after"}, {31'h0, sel ? b_rsp_valid : a_rsp_valid}, 32'h0);
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_cmd_ready", {31'h0, a_cmd_ready}, 32'h0);
        chk("rst_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", a_rsp_rdata, 32'h0);
        chk("rst_rsp_err",   {31'h0, a_rsp_err}, 32'h0);
        chk("rst_address",   {26'h0, a_bus_address}, 32'h0);
        chk("rst_wdata",     a_bus_wdata, 32'h0);
        chk("rst_write_n",   {30'h0, a_bus_write_n}, 32'h3);
        chk("rst_read_n",    {30'h0, a_bus_read_n}, 32'h3);
        chk("rst_b_cmd_ready", {31'h0, b_cmd_ready}, 32'h0);
        reset = 1'b0;
        step();
        chk("post_rst_ready", {31'h0, a_cmd_ready}, 32'h1);
        chk("post_rst_ready_b", {31'h0, b_cmd_ready}, 32'h1);

        // CORDIC write: strobe in T+1 only, response in T+2
        issue(1'b0, 1'b1, 2'b10, 6'h00, 32'h3F800000);
        chk("wr_write_n", {30'h0, a_bus_write_n}, 32'h2);
        chk("wr_read_n",  {30'h0, a_bus_read_n}, 32'h3);
        chk("wr_addr",    {26'h0, a_bus_address}, 32'h0);
        chk("wr_wdata",   a_bus_wdata, 32'h3F800000);
        chk("wr_cmd_ready", {31'h0, a_cmd_ready}, 32'h0);
        chk("wr_rsp_early", {31'h0, a_rsp_valid}, 32'h0);
        step();
        chk("wr_write_n_off", {30'h0, a_bus_write_n}, 32'h3);
        chk("wr_rsp_valid", {31'h0, a_rsp_valid}, 32'h1);
        chk("wr_rsp_err",   {31'h0, a_rsp_err}, 32'h0);
        chk("wr_rsp_rdata", a_rsp_rdata, 32'h0);
        finish_rsp(1'b0, "wr");

        // Waited read: ready low 5 cycles, high in the 6th strobe cycle
        bus_rdata = 32'h3F0A1B2C;
        issue(1'b0, 1'b0, 2'b10, 6'h02, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("rdw_read_n_%0d", k), {30'h0, a_bus_read_n}, 32'h2);
            chk($sformatf("rdw_addr_%0d", k), {26'h0, a_bus_address}, 32'h2);
            chk($sformatf("rdw_write_n_%0d", k), {30'h0, a_bus_write_n}, 32'h3);
            chk($sformatf("rdw_no_rsp_%0d", k), {31'h0, a_rsp_valid}, 32'h0);
            if (k == 6) bus_ready = 1'b1;
            step();
        end
        bus_ready = 1'b0;
        chk("rdw_read_n_off", {30'h0, a_bus_read_n}, 32'h3);
        chk("rdw_rsp_valid", {31'h0, a_rsp_valid}, 32'h1);
        chk("rdw_rdata", a_rsp_rdata, 32'h3F0A1B2C);
        chk("rdw_err", {31'h0, a_rsp_err}, 32'h0);
        // Response back-pressure
        bus_rdata = 32'h11111111;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("bp_valid_%0d", k), {31'h0, a_rsp_valid}, 32'h1);
            chk($sformatf("bp_rdata_%0d", k), a_rsp_rdata, 32'h3F0A1B2C);
            chk($sformatf("bp_err_%0d", k), {31'h0, a_rsp_err}, 32'h0);
            chk($sformatf("bp_cmd_ready_%0d", k), {31'h0, a_cmd_ready}, 32'h0);
        end
        finish_rsp(1'b0, "rdw");

        // Read8 and Read16 size masking, zero-wait
        bus_rdata = 32'hDEADBEEF;
        bus_ready = 1'b1;
        issue(1'b0, 1'b0, 2'b00, 6'h04, 32'h0);
        chk("rd8_read_n", {30'h0, a_bus_read_n}, 32'h0);
        step();
        chk("rd8_valid", {31'h0, a_rsp_valid}, 32'h1);
        chk("rd8_rdata", a_rsp_rdata, 32'h000000EF);
        chk("rd8_read_n_off", {30'h0, a_bus_read_n}, 32'h3);
        finish_rsp(1'b0, "rd8");
        issue(1'b0, 1'b0, 2'b01, 6'h05, 32'h0);
        chk("rd16_read_n", {30'h0, a_bus_read_n}, 32'h1);
        step();
        chk("rd16_valid", {31'h0, a_rsp_valid}, 32'h1);
        chk("rd16_rdata", a_rsp_rdata, 32'h0000BEEF);
        chk("rd16_err", {31'h0, a_rsp_err}, 32'h0);
        finish_rsp(1'b0, "rd16");

        // Illegal size: error response at T+1, no bus strobe
        issue(1'b0, 1'b1, 2'b11, 6'h07, 32'hCAFEF00D);
        chk("ill_valid", {31'h0, a_rsp_valid}, 32'h1);
        chk("ill_err", {31'h0, a_rsp_err}, 32'h1);
        chk("ill_rdata", a_rsp_rdata, 32'h0);
        chk("ill_write_n", {30'h0, a_bus_write_n}, 32'h3);
        chk("ill_read_n", {30'h0, a_bus_read_n}, 32'h3);
        finish_rsp(1'b0, "ill");
        bus_ready = 1'b0;

        // TIMEOUT=4: ready in the 4th strobe cycle still returns data
        bus_rdata = 32'h12345678;
        issue(1'b1, 1'b0, 2'b10, 6'h09, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("lim_read_n_%0d", k), {30'h0, b_bus_read_n}, 32'h2);
            if (k == 4) bus_ready = 1'b1;
            step();
        end
        bus_ready = 1'b0;
        chk("lim_valid", {31'h0, b_rsp_valid}, 32'h1);
        chk("lim_err", {31'h0, b_rsp_err}, 32'h0);
        chk("lim_rdata", b_rsp_rdata, 32'h12345678);
        chk("lim_a_idle", {30'h0, a_bus_read_n}, 32'h3);
        finish_rsp(1'b1, "lim");

        // TIMEOUT=4: ready stuck low gives 4 strobe cycles then error
        bus_rdata = 32'hFFFFFFFF;
        issue(1'b1, 1'b0, 2'b10, 6'h0A, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("to_read_n_%0d", k), {30'h0, b_bus_read_n}, 32'h2);
            chk($sformatf("to_no_rsp_%0d", k), {31'h0, b_rsp_valid}, 32'h0);
            step();
        end
        chk("to_read_n_off", {30'h0, b_bus_read_n}, 32'h3);
        chk("to_valid", {31'h0, b_rsp_valid}, 32'h1);
        chk("to_err", {31'h0, b_rsp_err}, 32'h1);
        chk("to_rdata", b_rsp_rdata, 32'h0);
        finish_rsp(1'b1, "to");

        // Reset asserted mid-READ aborts the transaction
        issue(1'b0, 1'b0, 2'b10, 6'h03, 32'h0);
        chk("rr_read_n", {30'h0, a_bus_read_n}, 32'h2);
        step();
        reset = 1'b1;
        step();
        chk("rr_read_n_idle", {30'h0, a_bus_read_n}, 32'h3);
        chk("rr_no_rsp", {31'h0, a_rsp_valid}, 32'h0);
        chk("rr_cmd_ready_low", {31'h0, a_cmd_ready}, 32'h0);
        reset = 1'b0;
        step();
        chk("rr_cmd_ready", {31'h0, a_cmd_ready}, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("rr_quiet_rsp_%0d", k), {31'h0, a_rsp_valid}, 32'h0);
            chk($sformatf("rr_quiet_bus_%0d", k), {30'h0, a_bus_read_n}, 32'h3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
